// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one DMEM port among NUM_PORTS cores; one access issued per cycle.
// Grant/mem outputs registered one cycle after selection; rvalid returns READ_LATENCY cycles after mem_en.
module dmem_rr_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [NUM_PORTS-1:0]             rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             mem_en,
  output logic                             mem_wr_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]      gnt_idx_q;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  mem_en_q;
  logic                  mem_wr_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [NUM_PORTS-1:0]  eligible;
  logic                  sel_vld;
  logic [PTR_W-1:0]      sel_idx;
  logic                  tag_vld_q  [READ_LATENCY];
  logic [PTR_W-1:0]      tag_port_q [READ_LATENCY];

  // A port granted last cycle sits out one cycle so its next access is not confused with the one just taken.
  assign eligible = req & ~gnt_q;

  always_comb begin
    int         cand;
    logic [PTR_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = PTR_W'(cand);
      if (!sel_vld && eligible[cand_idx]) begin
        sel_vld = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_d    = '0;
    rr_ptr_d = rr_ptr_q;
    if (sel_vld) begin
      gnt_d[sel_idx] = 1'b1;
      rr_ptr_d = (sel_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : sel_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_en_q    <= sel_vld;
      mem_wr_en_q <= sel_vld & we[sel_idx];
      if (sel_vld) begin
        gnt_idx_q   <= sel_idx;
        mem_addr_q  <= addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_q <= wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Tags enter as the read is presented to DMEM, so the last stage lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        tag_vld_q[s]  <= 1'b0;
        tag_port_q[s] <= '0;
      end
    end else begin
      for (int s = READ_LATENCY - 1; s > 0; s--) begin
        tag_vld_q[s]  <= tag_vld_q[s-1];
        tag_port_q[s] <= tag_port_q[s-1];
      end
      tag_vld_q[0]  <= mem_en_q & ~mem_wr_en_q;
      tag_port_q[0] <= gnt_idx_q;
    end
  end

  always_comb begin
    rvalid = '0;
    if (tag_vld_q[READ_LATENCY-1]) rvalid[tag_port_q[READ_LATENCY-1]] = 1'b1;
  end

  assign gnt       = gnt_q;
  assign rdata     = mem_rdata;
  assign mem_en    = mem_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed bench for dmem_rr_arbiter with a one-cycle-latency DMEM model.
module tb_dmem_rr_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int RL = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [NP-1:0]      req, we, gnt, rvalid;
  logic [NP*AW-1:0]   addr;
  logic [NP*DW-1:0]   wdata;
  logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
  logic               mem_en, mem_wr_en;
  logic [AW-1:0]      mem_addr;

  logic [DW-1:0]      mem [256];
  logic [DW-1:0]      mem_rdata_q;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_rr_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wdata;
      else           mem_rdata_q <= mem[mem_addr[7:0]];
    end
  end
  assign mem_rdata = mem_rdata_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    we    = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [NP-1:0] exp_g [5];
  logic [NP-1:0] exp_r [5];
  logic [DW-1:0] exp_d [5];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem[8'h10]  = 64'hAA55;
    mem[8'h40]  = 64'hD0;
    mem[8'h41]  = 64'hD1;
    mem[8'h42]  = 64'hD2;
    mem[8'h43]  = 64'hD3;
    mem_rdata_q = '0;
    addr  = '0;
    wdata = '0;

    // Reset state
    do_reset();
    chk("rst_gnt",       64'(gnt),       64'h0);
    chk("rst_rvalid",    64'(rvalid),    64'h0);
    chk("rst_mem_en",    64'(mem_en),    64'h0);
    chk("rst_mem_wr_en", 64'(mem_wr_en), 64'h0);
    chk("rst_mem_addr",  64'(mem_addr),  64'h0);
    chk("rst_mem_wdata", mem_wdata,      64'h0);

    // Single read from port 0
    set_port(0, 32'h10, 64'h0);
    req = 4'b0001;
    we  = 4'b0000;
    tick();
    chk("rd_gnt",       64'(gnt),       64'h1);
    chk("rd_mem_en",    64'(mem_en),    64'h1);
    chk("rd_mem_addr",  64'(mem_addr),  64'h10);
    chk("rd_mem_wr_en", 64'(mem_wr_en), 64'h0);
    chk("rd_rvalid0",   64'(rvalid),    64'h0);
    req = 4'b0000;
    tick();
    chk("rd_rvalid",    64'(rvalid),    64'h1);
    chk("rd_rdata",     rdata,          64'hAA55);
    chk("rd_gnt_idle",  64'(gnt),       64'h0);

    // Round-robin with all four ports reading
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 32'h40 + p, 64'h0);
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_d = '{64'h0,   64'hD0,  64'hD1,  64'hD2,  64'hD3};
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("rr_gnt%0d", c),    64'(gnt),    64'(exp_g[c]));
      chk($sformatf("rr_rvalid%0d", c), 64'(rvalid), 64'(exp_r[c]));
      if (c > 0) chk($sformatf("rr_rdata%0d", c), rdata, exp_d[c]);
    end
    req = 4'b0000;
    tick();
    chk("rr_gnt_end",    64'(gnt),    64'h0);
    chk("rr_rvalid_end", 64'(rvalid), 64'h1);
    chk("rr_rdata_end",  rdata,       64'hD0);
    tick();
    chk("rr_rvalid_idle", 64'(rvalid), 64'h0);

    // Port 2 holding req is served every other cycle
    do_reset();
    set_port(2, 32'h10, 64'h0);
    req = 4'b0100;
    tick();
    chk("hold_gnt1",    64'(gnt),    64'h4);
    chk("hold_en1",     64'(mem_en), 64'h1);
    tick();
    chk("hold_gnt2",    64'(gnt),    64'h0);
    chk("hold_en2",     64'(mem_en), 64'h0);
    chk("hold_addr2",   64'(mem_addr), 64'h10);
    chk("hold_rvalid2", 64'(rvalid), 64'h4);
    tick();
    chk("hold_gnt3",    64'(gnt),    64'h4);
    chk("hold_en3",     64'(mem_en), 64'h1);
    req = 4'b0000;
    tick();
    chk("hold_gnt4",    64'(gnt),    64'h0);
    chk("hold_en4",     64'(mem_en), 64'h0);
    chk("hold_rvalid4", 64'(rvalid), 64'h4);

    // Pointer wrap: pointer sits at 3 after port 2
    set_port(0, 32'h40, 64'h0);
    set_port(3, 32'h43, 64'h0);
    req = 4'b1001;
    tick();
    chk("wrap_gnt3", 64'(gnt), 64'h8);
    chk("wrap_addr3", 64'(mem_addr), 64'h43);
    tick();
    chk("wrap_gnt0", 64'(gnt), 64'h1);
    chk("wrap_rv3",  64'(rvalid), 64'h8);
    chk("wrap_rd3",  rdata, 64'hD3);
    req = 4'b0000;
    tick();
    chk("wrap_rv0",  64'(rvalid), 64'h1);
    chk("wrap_rd0",  rdata, 64'hD0);

    // Mixed: port 0 store then port 1 load of the same address
    do_reset();
    set_port(0, 32'h20, 64'h1234);
    set_port(1, 32'h20, 64'h9999);
    req = 4'b0011;
    we  = 4'b0001;
    tick();
    chk("mix_gnt0",   64'(gnt),       64'h1);
    chk("mix_wr_en0", 64'(mem_wr_en), 64'h1);
    chk("mix_wdata0", mem_wdata,      64'h1234);
    chk("mix_addr0",  64'(mem_addr),  64'h20);
    req = 4'b0010;
    tick();
    chk("mix_gnt1",   64'(gnt),       64'h2);
    chk("mix_wr_en1", 64'(mem_wr_en), 64'h0);
    chk("mix_rv_wr",  64'(rvalid),    64'h0);
    req = 4'b0000;
    we  = 4'b0000;
    tick();
    chk("mix_rv1",    64'(rvalid),    64'h2);
    chk("mix_rdata1", rdata,          64'h1234);

    // Reset while a read is in flight
    set_port(1, 32'h10, 64'h0);
    req = 4'b0010;
    tick();
    chk("rstm_gnt", 64'(gnt), 64'h2);
    req   = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstm_gnt0",   64'(gnt),       64'h0);
    chk("rstm_rvalid", 64'(rvalid),    64'h0);
    chk("rstm_en",     64'(mem_en),    64'h0);
    chk("rstm_wr_en",  64'(mem_wr_en), 64'h0);
    chk("rstm_addr",   64'(mem_addr),  64'h0);
    chk("rstm_wdata",  mem_wdata,      64'h0);
    tick();
    chk("rstm_rvalid2", 64'(rvalid),   64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Round-robin arbiter that shares one data-memory port among the per-core DMEM request ports of the 4-core CMP.
- Each core presents enable, write-enable, address and store data. The arbiter issues one access per cycle to the shared DMEM and returns grant and read-valid pulses to the originating core.
- Sits between the core array and a single synchronous DMEM with fixed read latency.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8); PTR_W = clog2(NUM_PORTS).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, data width.
- READ_LATENCY, 1, cycles from mem_en to mem_rdata valid (1..4).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_PORTS  per-core access request (core memEn).
- we  in  NUM_PORTS  per-core write enable (core memWrEn); 1 = store.
- addr  in  NUM_PORTS*ADDR_WIDTH  flattened addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  NUM_PORTS*DATA_WIDTH  flattened store data; same packing.
- gnt  out  NUM_PORTS  one-hot, one-cycle pulse: request accepted.
- rvalid  out  NUM_PORTS  one-hot, one-cycle pulse: rdata holds this port's load result.
- rdata  out  DATA_WIDTH  load data broadcast to all cores.
- mem_en  out  1  shared DMEM enable.
- mem_wr_en  out  1  shared DMEM write enable.
- mem_addr  out  ADDR_WIDTH  shared DMEM address.
- mem_wdata  out  DATA_WIDTH  shared DMEM store data.
- mem_rdata  in  DATA_WIDTH  DMEM read data, valid READ_LATENCY cycles after mem_en.

Behaviour:
- Reset (reset=1 at an edge):
  - gnt, rvalid, mem_en, mem_wr_en = 0; mem_addr, mem_wdata = 0; rr_ptr = 0.
  - Read-tag pipeline cleared, so in-flight loads are discarded and no rvalid is produced for them.
- Eligibility: eligible[i] = req[i] & ~gnt[i]. A port granted in the previous cycle is masked for one cycle, so a requester holding req continuously is served at most every other cycle.
- Selection (combinational, cycle N):
  - Search starts at rr_ptr, ascending, wrapping at NUM_PORTS-1 to 0.
  - The first eligible port k wins. If none is eligible, there is no issue.
- Issue (registered, visible in cycle N+1):
  - gnt[k] = 1; mem_en = 1; mem_wr_en = we[k]; mem_addr = addr[k]; mem_wdata = wdata[k].
  - rr_ptr = (k+1) mod NUM_PORTS.
  - With no issue: gnt = 0, mem_en = 0, mem_wr_en = 0, mem_addr/mem_wdata hold their last value, rr_ptr unchanged.
- Requester rule: in the cycle gnt[i] is seen, the core either deasserts req[i] or presents its next access. That access is eligible from the following cycle.
- Read return:
  - A read issue (we[k]=0) pushes {valid=1, port=k} into a READ_LATENCY-deep tag shift register.
  - When the tag exits (cycle N+1+READ_LATENCY), rvalid[k] = 1 and rdata = mem_rdata (combinational pass-through).
  - rvalid = 0 otherwise. rdata follows mem_rdata at all times.
- Writes produce no rvalid.
- Throughput: one access per cycle when 2 or more ports are eligible. Reads and writes may interleave freely; ordering is issue order.
- Fairness: a continuously requesting port waits at most NUM_PORTS-1 grants to other ports.
- Simultaneous events: a tag exiting and a new issue in the same cycle are independent, both occur.
- Reset mid-stream: the outstanding grant and tags are dropped. Cores reissue after reset.
- Invariants: gnt and rvalid are always one-hot or zero. mem_en == |gnt every cycle.

Test Plan:
- Single read: reset, then req=0001, we=0, addr0=0x10 for 1 cycle -> next cycle gnt=0001, mem_en=1, mem_addr=0x10, mem_wr_en=0. With READ_LATENCY=1 and DMEM returning 0xAA55, rvalid=0001 and rdata=0xAA55 two cycles after the request.
- Round-robin: all four req held high with we=0 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; rvalid sequence identical, shifted by READ_LATENCY.
- Mask/hold: only port 2 holds req -> gnt=0100 on alternate cycles only; mem_en toggles 1,0,1,0.
- Mixed: port0 write (addr 0x20, data 0x1234), port1 read addr 0x20, same cycle -> port0 granted first, mem_wr_en=1 with data 0x1234. Port1 is granted the next cycle and rvalid=0010 returns 0x1234. No rvalid for port0.
- Pointer wrap: rr_ptr=3 after granting port2, req=1001 -> port3 is granted, then port0.
- Reset mid-read: issue a read to port1, assert reset the next cycle -> rvalid stays 0000 and all outputs are 0 in the cycle after reset.
